// File: rtl/bitgen_pkg.sv
// Shared constants and FSM encoding for the LFSR payload frame sequencer.
// DEFAULT_SEED stands in for an all-zero seed, which would lock the LFSR.
package bitgen_pkg;

    localparam int LFSR_LEN  = 256;
    localparam int PAYLOAD_K = 239;

    localparam logic [LFSR_LEN-1:0] DEFAULT_SEED = {
        64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
        64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/bitgen_frame_ctrl_if.sv
// Payload word stream from the frame sequencer to the product-code encoder.
// A word transfers on a rising edge with m_valid & m_ready both high; once m_valid
// rises, m_valid, m_data and m_last hold steady until that transfer happens.
interface bitgen_frame_ctrl_if #(
    parameter int K = bitgen_pkg::PAYLOAD_K
);
    logic [K-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bitgen_skid_fifo.sv
// Two-entry FIFO holding {last, data} words between generator capture and the stream port.
// Push and pop in the same cycle on a full FIFO is allowed and leaves occupancy unchanged.
module bitgen_skid_fifo #(
    parameter int W = 240
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   occ_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   occ_q;
    logic [1:0]   occ_d;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    always_comb begin
        occ_d = occ_q;
        if (do_push && !do_pop) begin
            occ_d = occ_q + 2'd1;
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;
endmodule

// File: rtl/bitgen_frame_ctrl.sv
// Frame sequencer: seeds the external LFSR generator, steps it once per payload word
// and streams each word to the encoder through a 2-entry skid FIFO.
module bitgen_frame_ctrl
    import bitgen_pkg::*;
#(
    parameter int LEN         = LFSR_LEN,
    parameter int K           = PAYLOAD_K,
    parameter int FRAME_WORDS = 239,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [LEN-1:0]             seed_in,
    output logic                       gen_load,
    output logic                       gen_step,
    output logic [LEN-1:0]             gen_seed,
    input  logic [K-1:0]               gen_bits,
    bitgen_frame_ctrl_if.master        m,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           words_sent,
    output state_e                     dbg_state_o
);
    localparam logic [CNT_W-1:0] FW_C   = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_WORDS - 1);

    state_e           state_q;
    logic [LEN-1:0]   seed_q;
    logic [LEN-1:0]   seed_d;
    logic             gen_load_q;
    logic             in_flight_q;
    logic             in_flight_last_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] words_sent_q;

    logic             aborting;
    logic             pop;
    logic             push;
    logic [1:0]       occ;
    logic [2:0]       credit_used;
    logic [K:0]       head;

    assign aborting = abort && (state_q != ST_IDLE);
    assign pop      = m.m_valid && m.m_ready;
    assign push     = in_flight_q && !aborting;
    assign seed_d   = (seed_in == '0) ? LEN'(DEFAULT_SEED) : seed_in;

    // A step issued now lands in the FIFO next cycle; counting this cycle's pop as freed
    // space lets a held-high ready sustain one word per cycle without overfilling.
    assign credit_used = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, pop};
    assign gen_step    = (state_q == ST_RUN) && !abort && (issued_q < FW_C)
                         && (credit_used < 3'd2);

    bitgen_skid_fifo #(.W(K + 1)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (aborting),
        .push_i      (push),
        .push_data_i ({in_flight_last_q, gen_bits}),
        .pop_i       (pop),
        .head_o      (head),
        .occ_o       (occ)
    );

    assign m.m_valid = (occ != 2'd0);
    assign m.m_data  = head[K-1:0];
    assign m.m_last  = head[K] && m.m_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            seed_q           <= '0;
            gen_load_q       <= 1'b0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            issued_q         <= '0;
            words_sent_q     <= '0;
        end else begin
            gen_load_q       <= 1'b0;
            done_q           <= 1'b0;
            in_flight_q      <= gen_step;
            in_flight_last_q <= gen_step && (issued_q == LAST_C);
            if (pop && (words_sent_q != FW_C)) begin
                words_sent_q <= words_sent_q + CNT_W'(1);
            end
            if (aborting) begin
                state_q          <= ST_IDLE;
                busy_q           <= 1'b0;
                in_flight_q      <= 1'b0;
                in_flight_last_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            seed_q       <= seed_d;
                            gen_load_q   <= 1'b1;
                            busy_q       <= 1'b1;
                            issued_q     <= '0;
                            words_sent_q <= '0;
                            state_q      <= ST_LOAD;
                        end
                    end
                    ST_LOAD: state_q <= ST_RUN;
                    ST_RUN: begin
                        if (gen_step) begin
                            issued_q <= issued_q + CNT_W'(1);
                        end
                        if (issued_q == FW_C) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if ((occ == 2'd0) && !in_flight_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign gen_load    = gen_load_q;
    assign gen_seed    = seed_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign words_sent  = words_sent_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_bitgen_frame_ctrl.sv
// Bench for bitgen_frame_ctrl: behavioural LFSR generator plus an expected-word queue
// built from the seed, with randomized seeds and back-pressure.
module tb_bitgen_frame_ctrl;
    import bitgen_pkg::*;

    localparam int LEN   = 256;
    localparam int K     = 239;
    localparam int FW    = 4;
    localparam int CNT_W = 3;
    localparam logic [LEN-1:0] DEF_SEED = {
        64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
        64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978
    };

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [LEN-1:0]   seed_in;
    logic             gen_load;
    logic             gen_step;
    logic [LEN-1:0]   gen_seed;
    logic [K-1:0]     gen_bits;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_sent;
    state_e           dbg_state;

    bitgen_frame_ctrl_if #(.K(K)) m_if ();

    bitgen_frame_ctrl #(.LEN(LEN), .K(K), .FRAME_WORDS(FW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .seed_in(seed_in),
        .gen_load(gen_load), .gen_step(gen_step), .gen_seed(gen_seed), .gen_bits(gen_bits),
        .m(m_if), .busy(busy), .done(done), .words_sent(words_sent), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- golden LFSR generator ----------------
    function automatic logic [LEN-1:0] lfsr_adv(input logic [LEN-1:0] s);
        logic fb;
        for (int i = 0; i < K; i++) begin
            fb = s[255] ^ s[253] ^ s[250] ^ s[245];
            s  = {s[LEN-2:0], fb};
        end
        return s;
    endfunction

    logic [LEN-1:0] gen_state;
    always @(posedge clk or posedge reset) begin
        if (reset)         gen_state <= '0;
        else if (gen_load) gen_state <= gen_seed;
        else if (gen_step) gen_state <= lfsr_adv(gen_state);
    end
    assign gen_bits = gen_state[K-1:0];

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [LEN-1:0] got, input logic [LEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [K-1:0]   exp_q[$];
    logic [LEN-1:0] exp_seed;
    int load_cnt, step_cnt, acc_cnt, done_cnt, first_step, last_step, first_valid_t;
    logic [K-1:0] first_word;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_last = 1'b0;
    logic [K-1:0] prev_data = '0;

    always begin
        logic [K-1:0] w;
        @(negedge clk);
        #2;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (gen_load || gen_step) check("load_step_excl", LEN'(gen_load & gen_step), '0);
            if (gen_load) begin
                load_cnt++;
                check("gen_seed_at_load", gen_seed, exp_seed);
            end
            if (gen_step) begin
                if (first_step < 0) first_step = cyc;
                last_step = cyc;
                step_cnt++;
            end
            if (m_if.m_valid && first_valid_t < 0) first_valid_t = cyc;
            if (prev_valid && !prev_ready && !prev_abort) begin
                check("hold_valid", LEN'(m_if.m_valid), 1);
                check("hold_data", LEN'(m_if.m_data), LEN'(prev_data));
                check("hold_last", LEN'(m_if.m_last), LEN'(prev_last));
            end
            if (m_if.m_valid && m_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("m_data", LEN'(m_if.m_data), LEN'(w));
                    check("m_last", LEN'(m_if.m_last), LEN'(acc_cnt == FW - 1));
                end
                if (acc_cnt == 0) first_word = m_if.m_data;
                acc_cnt++;
            end
            if (busy) check("steps_ahead", LEN'((step_cnt - acc_cnt) <= 2), 1);
            if (done) done_cnt++;
            prev_valid = m_if.m_valid;
            prev_ready = m_if.m_ready;
            prev_abort = abort;
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [LEN-1:0] rand_seed();
        logic [LEN-1:0] s;
        for (int i = 0; i < LEN / 32; i++) s = {s[LEN-33:0], $urandom()};
        return s;
    endfunction

    task automatic frame_setup(input logic [LEN-1:0] seed);
        logic [LEN-1:0] s;
        exp_seed = (seed == '0) ? DEF_SEED : seed;
        exp_q.delete();
        s = exp_seed;
        for (int i = 0; i < FW; i++) begin
            s = lfsr_adv(s);
            exp_q.push_back(s[K-1:0]);
        end
        load_cnt = 0; step_cnt = 0; acc_cnt = 0; done_cnt = 0;
        first_step = -1; last_step = -1; first_valid_t = -1;
    endtask

    // mode 0: ready always high; 1: random ready; 2: 10-cycle stall after first word
    task automatic run_frame(input logic [LEN-1:0] seed, input int mode, input bit stray_start);
        int t0, guard, stall;
        frame_setup(seed);
        m_if.m_ready = 1'b1;
        start = 1'b1; seed_in = seed; t0 = cyc;
        tick();
        start = 1'b0; seed_in = rand_seed();
        guard = 0; stall = 0;
        while (done_cnt == 0 && guard < 300) begin
            case (mode)
                1: m_if.m_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (acc_cnt >= 1 && stall < 10) begin
                        m_if.m_ready = 1'b0;
                        stall++;
                    end else begin
                        m_if.m_ready = 1'b1;
                    end
                end
                default: m_if.m_ready = 1'b1;
            endcase
            start = stray_start && (guard == 3);
            tick();
            guard++;
        end
        start = 1'b0;
        m_if.m_ready = 1'b1;
        check("done_seen", LEN'(done_cnt != 0), 1);
        tick();
        tick();
        check("busy_after", LEN'(busy), 0);
        check("valid_after", LEN'(m_if.m_valid), 0);
        check("words_accepted", LEN'(acc_cnt), LEN'(FW));
        check("words_left", LEN'(exp_q.size()), 0);
        check("step_pulses", LEN'(step_cnt), LEN'(FW));
        check("load_pulses", LEN'(load_cnt), 1);
        check("done_pulses", LEN'(done_cnt), 1);
        check("words_sent", LEN'(words_sent), LEN'(FW));
        if (mode == 0) begin
            check("latency", LEN'(first_valid_t - t0), 4);
            check("steps_b2b", LEN'(last_step - first_step), LEN'(FW - 1));
        end
    endtask

    task automatic abort_test();
        logic [LEN-1:0] seed;
        logic [K-1:0]   w_a;
        int guard;
        seed = rand_seed();
        frame_setup(seed);
        m_if.m_ready = 1'b1;
        start = 1'b1; seed_in = seed;
        tick();
        start = 1'b0;
        guard = 0;
        while (first_valid_t < 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("abort_first_valid", LEN'(first_valid_t >= 0), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", LEN'(busy), 0);
        check("abort_valid", LEN'(m_if.m_valid), 0);
        check("abort_gen", LEN'(gen_load | gen_step), 0);
        w_a = first_word;
        repeat (6) tick();
        check("abort_no_done", LEN'(done_cnt), 0);
        run_frame(seed, 0, 1'b0);
        check("abort_restart_word", LEN'(first_word), LEN'(w_a));
    endtask

    task automatic reset_drain_test();
        int guard;
        frame_setup(rand_seed());
        m_if.m_ready = 1'b1;
        start = 1'b1; seed_in = exp_seed;
        tick();
        start = 1'b0;
        guard = 0;
        while (acc_cnt < 2 && guard < 50) begin
            tick();
            guard++;
        end
        m_if.m_ready = 1'b0;
        repeat (6) tick();
        check("drain_state", LEN'(dbg_state), LEN'(ST_DRAIN));
        check("drain_valid", LEN'(m_if.m_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_gen_load", LEN'(gen_load), 0);
        check("rst_gen_step", LEN'(gen_step), 0);
        check("rst_gen_seed", gen_seed, '0);
        check("rst_m_valid", LEN'(m_if.m_valid), 0);
        check("rst_m_last", LEN'(m_if.m_last), 0);
        check("rst_m_data", LEN'(m_if.m_data), '0);
        check("rst_busy", LEN'(busy), 0);
        check("rst_done", LEN'(done), 0);
        check("rst_words_sent", LEN'(words_sent), 0);
        tick();
        tick();
        reset = 1'b0;
        m_if.m_ready = 1'b1;
        exp_q.delete();
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; seed_in = '0; m_if.m_ready = 1'b1;
        exp_seed = '0;
        load_cnt = 0; step_cnt = 0; acc_cnt = 0; done_cnt = 0;
        first_step = -1; last_step = -1; first_valid_t = -1; first_word = '0;
        tick();
        tick();
        reset = 1'b0;
        check("init_gen_load", LEN'(gen_load), 0);
        check("init_gen_seed", gen_seed, '0);
        check("init_m_valid", LEN'(m_if.m_valid), 0);
        check("init_m_data", LEN'(m_if.m_data), '0);
        check("init_busy", LEN'(busy), 0);
        check("init_done", LEN'(done), 0);
        check("init_words_sent", LEN'(words_sent), 0);
        tick();

        run_frame(LEN'(1), 0, 1'b0);
        run_frame('0, 0, 1'b0);
        run_frame(rand_seed(), 2, 1'b0);
        run_frame(rand_seed(), 0, 1'b1);
        for (int i = 0; i < 4; i++) run_frame(rand_seed(), 1, 1'b0);

        // abort while idle must swallow a coincident start
        abort = 1'b1; start = 1'b1; seed_in = rand_seed();
        tick();
        abort = 1'b0; start = 1'b0;
        check("idle_abort_busy", LEN'(busy), 0);
        check("idle_abort_load", LEN'(gen_load), 0);
        tick();

        abort_test();
        reset_drain_test();
        run_frame(rand_seed(), 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
